// File: rtl/exec_div_iter.sv
// exec_div_iter: iterative integer divide lane for DIV/DIVU/REM/REMU.
// It produces one quotient bit per cycle using a restoring shift-subtract loop.
// The lane takes one op from the complex-FU issue slot, but only while it is idle.
// The result leaves as a single-cycle writeback packet. There is no backpressure.
//
// Handshake: an op is accepted on a rising clk edge when
//   issueValid_i & issueReady_o & ~recoverFlag_i
// issueReady_o is high only in IDLE. An issue seen while the lane is not ready
// is dropped; the issue logic holds or replays it. wbValid_o is a single-cycle
// strobe with no ready signal. recoverFlag_i kills any in-flight op.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   recoverFlag_i       pipeline flush
//   issueValid_i        op presented this cycle
//   issueReady_o        lane idle, will accept
//   fn_i                0=DIV 1=DIVU 2=REM 3=REMU
//   src1_i / src2_i     dividend / divisor
//   phyDest_i, logDest_i, alID_i, seqNo_i, destValid_i   tags carried with the op
//   wbValid_o           result valid (one cycle)
//   wbData_o            quotient or remainder
//   wbPhyDest_o, wbLogDest_o, wbAlID_o, wbSeqNo_o, wbDestValid_o   captured tags
//   dbgState_o          FSM state (0=IDLE 1=CALC 2=DONE)
module exec_div_iter #(
    parameter int DATA_WIDTH = 64,
    parameter int PHY_LOG    = 7,
    parameter int LOG_LOG    = 5,
    parameter int AL_LOG     = 7,
    parameter int SEQ_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  recoverFlag_i,
    input  logic                  issueValid_i,
    output logic                  issueReady_o,
    input  logic [1:0]            fn_i,
    input  logic [DATA_WIDTH-1:0] src1_i,
    input  logic [DATA_WIDTH-1:0] src2_i,
    input  logic [PHY_LOG-1:0]    phyDest_i,
    input  logic [LOG_LOG-1:0]    logDest_i,
    input  logic [AL_LOG-1:0]     alID_i,
    input  logic [SEQ_W-1:0]      seqNo_i,
    input  logic                  destValid_i,
    output logic                  wbValid_o,
    output logic [DATA_WIDTH-1:0] wbData_o,
    output logic [PHY_LOG-1:0]    wbPhyDest_o,
    output logic [LOG_LOG-1:0]    wbLogDest_o,
    output logic [AL_LOG-1:0]     wbAlID_o,
    output logic [SEQ_W-1:0]      wbSeqNo_o,
    output logic                  wbDestValid_o,
    output logic [1:0]            dbgState_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    localparam int                    CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MIN_INT  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                  state, nextState;
    logic [CNT_W-1:0]        count;
    logic [DATA_WIDTH-1:0]   quoReg, remReg, divisorReg, resData;
    logic                    isRem, negQuo, negRem;
    logic [PHY_LOG-1:0]      phyDestReg;
    logic [LOG_LOG-1:0]      logDestReg;
    logic [AL_LOG-1:0]       alIDReg;
    logic [SEQ_W-1:0]        seqNoReg;
    logic                    destValidReg;

    logic                    accept;
    logic                    isSigned, src1Neg, src2Neg;
    logic [DATA_WIDTH-1:0]   absA, absB;
    logic                    divZero, overflow, special;
    logic [DATA_WIDTH-1:0]   specialRes;
    logic [DATA_WIDTH:0]     shifted, diff;
    logic                    fits;
    logic [DATA_WIDTH-1:0]   remNext, quoNext, finalRes;

    assign accept = issueValid_i & issueReady_o & ~recoverFlag_i;

    // Operand preparation at accept. The loop always runs on magnitudes,
    // and the signs are applied once the last bit is done.
    always_comb begin
        isSigned   = ~fn_i[0];
        src1Neg    = isSigned & src1_i[DATA_WIDTH-1];
        src2Neg    = isSigned & src2_i[DATA_WIDTH-1];
        absA       = src1Neg ? -src1_i : src1_i;
        absB       = src2Neg ? -src2_i : src2_i;
        divZero    = (src2_i == '0);
        overflow   = isSigned & (src1_i == MIN_INT) & (src2_i == '1);
        special    = divZero | overflow;
        if (divZero)
            specialRes = fn_i[1] ? src1_i : '1;
        else
            specialRes = fn_i[1] ? '0 : src1_i;
    end

    // One restoring step. The partial remainder is always below the divisor.
    // Its shifted form therefore fits in DATA_WIDTH+1 bits, and the borrow bit
    // of diff tells us whether the subtract fits.
    always_comb begin
        shifted  = {remReg, quoReg[DATA_WIDTH-1]};
        diff     = shifted - {1'b0, divisorReg};
        fits     = ~diff[DATA_WIDTH];
        remNext  = fits ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
        quoNext  = {quoReg[DATA_WIDTH-2:0], fits};
        if (isRem)
            finalRes = negRem ? -remNext : remNext;
        else
            finalRes = negQuo ? -quoNext : quoNext;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (accept) nextState = special ? DONE : CALC;
            CALC:    if (count == CNT_W'(1)) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (recoverFlag_i) nextState = IDLE;
    end

    // Output logic. The packet is forced to zero outside a valid cycle.
    always_comb begin
        issueReady_o  = (state == IDLE);
        wbValid_o     = (state == DONE) & ~recoverFlag_i;
        wbData_o      = '0;
        wbPhyDest_o   = '0;
        wbLogDest_o   = '0;
        wbAlID_o      = '0;
        wbSeqNo_o     = '0;
        wbDestValid_o = 1'b0;
        dbgState_o    = state;
        if (wbValid_o) begin
            wbData_o      = resData;
            wbPhyDest_o   = phyDestReg;
            wbLogDest_o   = logDestReg;
            wbAlID_o      = alIDReg;
            wbSeqNo_o     = seqNoReg;
            wbDestValid_o = destValidReg;
        end
    end

    // Datapath. resData is preloaded with the special-case result at accept.
    // A normal op overwrites it on the last CALC cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count        <= '0;
            quoReg       <= '0;
            remReg       <= '0;
            divisorReg   <= '0;
            resData      <= '0;
            isRem        <= 1'b0;
            negQuo       <= 1'b0;
            negRem       <= 1'b0;
            phyDestReg   <= '0;
            logDestReg   <= '0;
            alIDReg      <= '0;
            seqNoReg     <= '0;
            destValidReg <= 1'b0;
        end else if (accept) begin
            count        <= CNT_LOAD;
            quoReg       <= absA;
            remReg       <= '0;
            divisorReg   <= absB;
            resData      <= specialRes;
            isRem        <= fn_i[1];
            negQuo       <= src1Neg ^ src2Neg;
            negRem       <= src1Neg;
            phyDestReg   <= phyDest_i;
            logDestReg   <= logDest_i;
            alIDReg      <= alID_i;
            seqNoReg     <= seqNo_i;
            destValidReg <= destValid_i;
        end else if (state == CALC) begin
            quoReg <= quoNext;
            remReg <= remNext;
            count  <= count - CNT_W'(1);
            if (count == CNT_W'(1)) resData <= finalRes;
        end
    end

endmodule

// File: tb/tb_exec_div_iter.sv
// Bench for exec_div_iter.
// Two lanes run side by side: one at DATA_WIDTH 32 and one at 64.
// Directed table vectors and hand-written sequences go to the 32-bit lane.
// Random traffic with recover pulses then runs on both lanes.
// A per-lane cycle model predicts ready, valid and the packet every cycle.
module tb_exec_div_iter;

    typedef struct packed {
        logic        valid;
        logic [1:0]  fn;
        logic [63:0] src1;
        logic [63:0] src2;
        logic [6:0]  phy;
        logic [4:0]  lg;
        logic [6:0]  al;
        logic [31:0] seq;
        logic        dv;
    } in_t;

    typedef struct packed {
        logic        ready;
        logic        valid;
        logic [63:0] data;
        logic [6:0]  phy;
        logic [4:0]  lg;
        logic [6:0]  al;
        logic [31:0] seq;
        logic        dv;
    } out_t;

    typedef struct {
        logic [115:0] pkt;
        int           done;
    } exp_t;

    typedef struct {
        logic [1:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        int          lat;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    in_t  in32, in64;
    logic rec32, rec64;

    logic        ready32, valid32, dv32;
    logic [31:0] data32, seq32;
    logic [6:0]  phy32, al32;
    logic [4:0]  lg32;
    logic [1:0]  dbg32;

    logic        ready64, valid64, dv64;
    logic [63:0] data64;
    logic [31:0] seq64;
    logic [6:0]  phy64, al64;
    logic [4:0]  lg64;
    logic [1:0]  dbg64;

    exec_div_iter #(.DATA_WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .recoverFlag_i(rec32),
        .issueValid_i(in32.valid), .issueReady_o(ready32), .fn_i(in32.fn),
        .src1_i(in32.src1[31:0]), .src2_i(in32.src2[31:0]),
        .phyDest_i(in32.phy), .logDest_i(in32.lg), .alID_i(in32.al),
        .seqNo_i(in32.seq), .destValid_i(in32.dv),
        .wbValid_o(valid32), .wbData_o(data32), .wbPhyDest_o(phy32),
        .wbLogDest_o(lg32), .wbAlID_o(al32), .wbSeqNo_o(seq32),
        .wbDestValid_o(dv32), .dbgState_o(dbg32)
    );

    exec_div_iter #(.DATA_WIDTH(64)) dut64 (
        .clk(clk), .reset(reset), .recoverFlag_i(rec64),
        .issueValid_i(in64.valid), .issueReady_o(ready64), .fn_i(in64.fn),
        .src1_i(in64.src1), .src2_i(in64.src2),
        .phyDest_i(in64.phy), .logDest_i(in64.lg), .alID_i(in64.al),
        .seqNo_i(in64.seq), .destValid_i(in64.dv),
        .wbValid_o(valid64), .wbData_o(data64), .wbPhyDest_o(phy64),
        .wbLogDest_o(lg64), .wbAlID_o(al64), .wbSeqNo_o(seq64),
        .wbDestValid_o(dv64), .dbgState_o(dbg64)
    );

    // ---------------- scoreboard state ----------------
    int   n_tests = 0;
    int   n_fail  = 0;
    out_t s_out [2];
    int   cyc   [2];
    exp_t exp_q0[$];
    exp_t exp_q1[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] mask_of(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic is_special(input logic [1:0] fn, input logic [63:0] a,
                                        input logic [63:0] b, input int w);
        logic [63:0] m;
        m = mask_of(w);
        return ((b & m) == 0) ||
               (!fn[0] && (a & m) == (64'(1) << (w - 1)) && (b & m) == m);
    endfunction

    function automatic logic [63:0] ref_result(input logic [1:0] fn, input logic [63:0] a,
                                               input logic [63:0] b, input int w);
        logic [63:0] m, ua, ub, r;
        longint      sa, sb;
        m  = mask_of(w);
        ua = a & m;
        ub = b & m;
        if (w == 64) begin
            sa = $signed(ua);
            sb = $signed(ub);
        end else begin
            sa = $signed(ua[31:0]);
            sb = $signed(ub[31:0]);
        end
        if (ub == 0)
            r = fn[1] ? ua : m;
        else if (!fn[0] && ua == (64'(1) << (w - 1)) && ub == m)
            r = fn[1] ? 64'(0) : ua;
        else if (fn[0])
            r = fn[1] ? (ua % ub) : (ua / ub);
        else
            r = fn[1] ? 64'(sa % sb) : 64'(sa / sb);
        return r & m;
    endfunction

    // Per-cycle lane model. There is at most one op in flight, and the model
    // knows the cycle its result is due.
    task automatic monitor(input int g, input int w, input logic rec, input in_t inp);
        out_t         o;
        exp_t         e;
        logic         has, exp_ready, exp_valid;
        logic [115:0] act_pkt;
        o = s_out[g];
        if (reset) begin
            if (g == 0) exp_q0.delete(); else exp_q1.delete();
            return;
        end
        cyc[g]++;
        has = (g == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
        if (has) e = (g == 0) ? exp_q0[0] : exp_q1[0];
        exp_ready = !has;
        exp_valid = has && (e.done == cyc[g]) && !rec;
        act_pkt   = {o.data, o.phy, o.lg, o.al, o.seq, o.dv};
        check($sformatf("w%0d ctrl cyc %0d", w, cyc[g]),
              128'({o.ready, o.valid, exp_valid ? 116'(0) : act_pkt}),
              128'({exp_ready, exp_valid, 116'(0)}));
        if (exp_valid)
            check($sformatf("w%0d packet cyc %0d", w, cyc[g]), 128'(act_pkt), 128'(e.pkt));
        if (has && (rec || e.done == cyc[g])) begin
            if (g == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
        end else if (!has && inp.valid && !rec) begin
            e.pkt  = {ref_result(inp.fn, inp.src1, inp.src2, w), inp.phy, inp.lg, inp.al, inp.seq, inp.dv};
            e.done = cyc[g] + (is_special(inp.fn, inp.src1, inp.src2, w) ? 1 : w + 1);
            if (g == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        end
    endtask

    // One clock: sample at the falling edge, then return just after the rising edge for driving.
    task automatic tick();
        @(negedge clk);
        s_out[0] = {ready32, valid32, 64'(data32), phy32, lg32, al32, seq32, dv32};
        s_out[1] = {ready64, valid64, data64, phy64, lg64, al64, seq64, dv64};
        monitor(0, 32, rec32, in32);
        monitor(1, 64, rec64, in64);
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_idle32();
        int guard = 0;
        while (!ready32 && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) check("wait idle timeout", 128'(0), 128'(1));
    endtask

    task automatic drive32(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b);
        in32.valid = 1'b1;
        in32.fn    = fn;
        in32.src1  = {32'h0, a};
        in32.src2  = {32'h0, b};
        in32.phy   = 7'($urandom_range(0, 127));
        in32.lg    = 5'($urandom_range(0, 31));
        in32.al    = 7'($urandom_range(0, 127));
        in32.seq   = $urandom;
        in32.dv    = 1'($urandom_range(0, 1));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   lat;
        in_t  sent;
        wait_idle32();
        drive32(v.fn, v.a, v.b);
        sent = in32;
        tick();
        in32.valid = 1'b0;
        lat = 0;
        while (!s_out[0].valid && lat < 50) begin
            tick();
            lat++;
        end
        check($sformatf("vec%0d latency", idx), 128'(lat), 128'(v.lat));
        check($sformatf("vec%0d data", idx), 128'(s_out[0].data), 128'(v.data));
        check($sformatf("vec%0d tags", idx),
              128'({s_out[0].phy, s_out[0].lg, s_out[0].al, s_out[0].seq, s_out[0].dv}),
              128'({sent.phy, sent.lg, sent.al, sent.seq, sent.dv}));
    endtask

    function automatic logic [63:0] rnd_val(input int w);
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: v = 64'(0);
            1: v = 64'(1);
            2: v = 64'hFFFF_FFFF_FFFF_FFFF;
            3: v = 64'(1) << (w - 1);
            4: v = v >> $urandom_range(0, w - 1);
            default: ;
        endcase
        if (w == 32) v[63:32] = 32'h0;
        return v;
    endfunction

    task automatic rand_lane(inout in_t inp, output logic rec, input int w);
        inp.valid = ($urandom_range(0, 3) != 0);
        inp.fn    = 2'($urandom_range(0, 3));
        inp.src1  = rnd_val(w);
        inp.src2  = rnd_val(w);
        inp.phy   = 7'($urandom_range(0, 127));
        inp.lg    = 5'($urandom_range(0, 31));
        inp.al    = 7'($urandom_range(0, 127));
        inp.seq   = $urandom;
        inp.dv    = 1'($urandom_range(0, 1));
        rec       = ($urandom_range(0, 99) == 0);
    endtask

    // ---------------- test ----------------
    vec_t vecs [11];
    int   pulses [$];
    int   nvalid;

    initial begin
        vecs[0]  = '{fn: 2'd1, a: 32'd100,        b: 32'd7,          data: 32'd14,         lat: 33};
        vecs[1]  = '{fn: 2'd3, a: 32'd100,        b: 32'd7,          data: 32'd2,          lat: 33};
        vecs[2]  = '{fn: 2'd0, a: 32'hFFFF_FFF9,  b: 32'd2,          data: 32'hFFFF_FFFD,  lat: 33};
        vecs[3]  = '{fn: 2'd2, a: 32'hFFFF_FFF9,  b: 32'd2,          data: 32'hFFFF_FFFF,  lat: 33};
        vecs[4]  = '{fn: 2'd2, a: 32'd7,          b: 32'hFFFF_FFFE,  data: 32'd1,          lat: 33};
        vecs[5]  = '{fn: 2'd0, a: 32'd5,          b: 32'd0,          data: 32'hFFFF_FFFF,  lat: 1};
        vecs[6]  = '{fn: 2'd3, a: 32'd9,          b: 32'd0,          data: 32'd9,          lat: 1};
        vecs[7]  = '{fn: 2'd0, a: 32'h8000_0000,  b: 32'hFFFF_FFFF,  data: 32'h8000_0000,  lat: 1};
        vecs[8]  = '{fn: 2'd2, a: 32'h8000_0000,  b: 32'hFFFF_FFFF,  data: 32'd0,          lat: 1};
        vecs[9]  = '{fn: 2'd1, a: 32'hFFFF_FFFF,  b: 32'd1,          data: 32'hFFFF_FFFF,  lat: 33};
        vecs[10] = '{fn: 2'd3, a: 32'd5,          b: 32'hFFFF_FFFF,  data: 32'd5,          lat: 33};

        cyc[0] = 0;
        cyc[1] = 0;
        in32  = '0;
        in64  = '0;
        rec32 = 1'b0;
        rec64 = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        check("reset ready32", 128'(ready32), 128'(1));
        check("reset out32", 128'({valid32, data32, phy32, lg32, al32, seq32, dv32}), 128'(0));
        check("reset ready64", 128'(ready64), 128'(1));
        check("reset out64", 128'({valid64, data64, phy64, lg64, al64, seq64, dv64}), 128'(0));
        reset = 1'b0;
        tick();

        // Table-driven vectors
        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Recover pulse at T+10 squashes the op
        wait_idle32();
        drive32(2'd1, 32'd1000, 32'd3);
        tick();
        in32.valid = 1'b0;
        repeat (9) tick();
        rec32 = 1'b1;
        tick();
        rec32 = 1'b0;
        tick();
        check("recover ready at T+11", 128'(s_out[0].ready), 128'(1));
        nvalid = 0;
        repeat (40) begin
            tick();
            if (s_out[0].valid) nvalid++;
        end
        check("recover no writeback", 128'(nvalid), 128'(0));
        run_vec(vecs[0], 100);

        // Issue held high: one result every DATA_WIDTH+2 cycles
        wait_idle32();
        drive32(2'd1, 32'd1234567, 32'd89);
        for (int i = 0; i < 102; i++) begin
            tick();
            if (s_out[0].valid) pulses.push_back(i);
        end
        in32.valid = 1'b0;
        check("held issue pulse count", 128'(pulses.size()), 128'(3));
        if (pulses.size() == 3)
            check("held issue pulse cycles", 128'({pulses[0], pulses[1], pulses[2]}),
                  128'({32'd33, 32'd67, 32'd101}));
        check("held issue data", 128'(s_out[0].data), 128'(32'd13871));

        // Async reset in the middle of CALC
        wait_idle32();
        drive32(2'd0, 32'd77777, 32'd5);
        tick();
        in32.valid = 1'b0;
        repeat (5) tick();
        #2;
        reset = 1'b1;
        #1;
        check("async reset ready", 128'(ready32), 128'(1));
        check("async reset outputs", 128'({valid32, data32, seq32}), 128'(0));
        tick();
        reset = 1'b0;
        tick();
        run_vec(vecs[1], 101);

        // Random traffic with recover pulses, both widths at once
        for (int c = 0; c < 30000; c++) begin
            rand_lane(in32, rec32, 32);
            rand_lane(in64, rec64, 64);
            tick();
        end
        in32.valid = 1'b0;
        in64.valid = 1'b0;
        rec32 = 1'b0;
        rec64 = 1'b0;
        repeat (70) tick();
        check("drain", 128'({exp_q0.size(), exp_q1.size()}), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
